perceptron_trainer: RTL and testbench

Training-sequencer stage that sits directly upstream of the perceptron core. It holds a small labelled training set and replays it to the core one sample at a time, epoch after epoch. For each sample it grades the core's 2-bit result against the label and counts mistakes. It stops when an epoch completes with zero mistakes (converged) or when MAX_EPOCHS epochs have run.

---
 rtl/perceptron_pkg.sv | 21 ++
 rtl/perceptron_sample_mem.sv | 33 +++
 rtl/perceptron_trainer.sv | 169 ++++++++++++++++
 tb/tb_perceptron_trainer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/perceptron_pkg.sv
// Shared types and constants for the perceptron training sequencer.
package perceptron_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    CHECK,
    EPOCH_END,
    DONE
  } state_t;

  localparam logic [1:0]  RES_POS   = 2'b01;
  localparam logic [1:0]  RES_NEG   = 2'b11;
  localparam int unsigned LABEL_BIT = 7;

  // A result is correct only for the exact code matching the label sign.
  function automatic logic result_ok(input logic label, input logic [1:0] res);
    return label ? (res == RES_POS) : (res == RES_NEG);
  endfunction

endpackage

// File: rtl/perceptron_sample_mem.sv
// Training-set register file: synchronous clear on reset, one write port,
// one combinational read port.
module perceptron_sample_mem #(
  parameter int unsigned NUM_SAMPLES = 8,
  parameter int unsigned ADDR_W      = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  logic [7:0] mem [NUM_SAMPLES];

  // Clear every entry on reset, otherwise accept in-range writes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_SAMPLES; i++) mem[i] <= '0;
    end else if (wr_en && (32'(wr_addr) < NUM_SAMPLES)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Out-of-range reads return zero.
  always_comb begin
    rd_data = '0;
    if (32'(rd_addr) < NUM_SAMPLES) rd_data = mem[rd_addr];
  end

endmodule

// File: rtl/perceptron_trainer.sv
// Training sequencer: replays the sample set to the perceptron core epoch
// after epoch, grades each result and stops on convergence or MAX_EPOCHS.
// Optional feature: define MISS_MASK_EN to add the per-sample miss_mask output.
module perceptron_trainer
  import perceptron_pkg::*;
#(
  parameter int unsigned NUM_SAMPLES = 8,
  parameter int unsigned ADDR_W      = 3,
  parameter int unsigned MAX_EPOCHS  = 32,
  parameter int unsigned SETTLE      = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_en,
  input  logic [ADDR_W-1:0]      load_addr,
  input  logic [7:0]             load_data,
  input  logic                   start,
  input  logic [7:0]             threshold_in,
  output logic [6:0]             p_in,
  output logic [7:0]             p_threshold,
  output logic                   p_exp_res,
  input  logic [1:0]             p_result,
  output logic                   busy,
  output logic                   done,
  output logic                   converged,
  output logic [7:0]             epoch_count,
  output logic [7:0]             err_count
`ifdef MISS_MASK_EN
  ,
  output logic [NUM_SAMPLES-1:0] miss_mask
`endif
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_SAMPLES - 1);

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [7:0]        settle_cnt;
  logic [7:0]        work_err;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              idle_like;
  logic              mem_wr;
  logic              start_ok;
  logic              mistake;

  assign idle_like = (state == IDLE) || (state == DONE);
  assign mem_wr    = load_en && idle_like;
  assign start_ok  = start && !load_en && idle_like;
  assign mistake   = (state == CHECK) && !result_ok(p_exp_res, p_result);

  // Address the sample that will be driven on the next DRIVE entry.
  always_comb begin
    rd_addr = '0;
    if (state == CHECK) rd_addr = idx + ADDR_W'(1);
  end

  perceptron_sample_mem #(
    .NUM_SAMPLES (NUM_SAMPLES),
    .ADDR_W      (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (mem_wr),
    .wr_addr (load_addr),
    .wr_data (load_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Threshold is a plain one-cycle pipeline to the core.
  always_ff @(posedge clk) begin
    if (!reset) p_threshold <= '0;
    else        p_threshold <= threshold_in;
  end

  // Sequencer FSM with all status and core-facing outputs registered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      idx         <= '0;
      settle_cnt  <= '0;
      work_err    <= '0;
      epoch_count <= '0;
      err_count   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      converged   <= 1'b0;
      p_in        <= '0;
      p_exp_res   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            state       <= DRIVE;
            idx         <= '0;
            settle_cnt  <= '0;
            work_err    <= '0;
            epoch_count <= '0;
            done        <= 1'b0;
            converged   <= 1'b0;
            busy        <= 1'b1;
            p_in        <= rd_data[6:0];
            p_exp_res   <= rd_data[LABEL_BIT];
          end
        end
        DRIVE: begin
          if (settle_cnt == 8'(SETTLE - 1)) state <= CHECK;
          else                              settle_cnt <= settle_cnt + 8'd1;
        end
        CHECK: begin
          if (mistake && (work_err != 8'hFF)) work_err <= work_err + 8'd1;
          if (idx == LAST_IDX) begin
            state     <= EPOCH_END;
            p_in      <= '0;
            p_exp_res <= 1'b0;
          end else begin
            state      <= DRIVE;
            idx        <= idx + ADDR_W'(1);
            settle_cnt <= '0;
            p_in       <= rd_data[6:0];
            p_exp_res  <= rd_data[LABEL_BIT];
          end
        end
        EPOCH_END: begin
          epoch_count <= epoch_count + 8'd1;
          err_count   <= work_err;
          if (work_err == '0) begin
            state     <= DONE;
            done      <= 1'b1;
            converged <= 1'b1;
            busy      <= 1'b0;
          end else if ((epoch_count + 8'd1) == 8'(MAX_EPOCHS)) begin
            state     <= DONE;
            done      <= 1'b1;
            converged <= 1'b0;
            busy      <= 1'b0;
          end else begin
            state      <= DRIVE;
            work_err   <= '0;
            idx        <= '0;
            settle_cnt <= '0;
            p_in       <= rd_data[6:0];
            p_exp_res  <= rd_data[LABEL_BIT];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MISS_MASK_EN
  logic [NUM_SAMPLES-1:0] work_mask;

  // Per-epoch record of which samples were graded wrong.
  always_ff @(posedge clk) begin
    if (!reset || start_ok) begin
      work_mask <= '0;
      miss_mask <= '0;
    end else if (mistake) begin
      work_mask[idx] <= 1'b1;
    end else if (state == EPOCH_END) begin
      miss_mask <= work_mask;
      work_mask <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_perceptron_trainer.sv
// Self-checking bench for perceptron_trainer with a table-driven stub core.
module tb_perceptron_trainer;

  localparam int NS  = 4;
  localparam int AW  = 2;
  localparam int MAXE = 3;
  localparam int ST  = 2;
  localparam int EPOCH_LEN = NS * (ST + 1) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [7:0]    load_data;
  logic          start;
  logic [7:0]    threshold_in;
  logic [6:0]    p_in;
  logic [7:0]    p_threshold;
  logic          p_exp_res;
  logic [1:0]    p_result;
  logic          busy;
  logic          done;
  logic          converged;
  logic [7:0]    epoch_count;
  logic [7:0]    err_count;
`ifdef MISS_MASK_EN
  logic [NS-1:0] miss_mask;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] mem_m [NS];
  logic [1:0] tab [256];
  logic [NS-1:0] exp_mask;

  always #5 clk = ~clk;

  // Stub core: response looked up from the full sample byte it is shown.
  always_comb p_result = tab[{p_exp_res, p_in}];

  perceptron_trainer #(
    .NUM_SAMPLES (NS),
    .ADDR_W      (AW),
    .MAX_EPOCHS  (MAXE),
    .SETTLE      (ST)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .load_en      (load_en),
    .load_addr    (load_addr),
    .load_data    (load_data),
    .start        (start),
    .threshold_in (threshold_in),
    .p_in         (p_in),
    .p_threshold  (p_threshold),
    .p_exp_res    (p_exp_res),
    .p_result     (p_result),
    .busy         (busy),
    .done         (done),
    .converged    (converged),
    .epoch_count  (epoch_count),
`ifdef MISS_MASK_EN
    .miss_mask    (miss_mask),
`endif
    .err_count    (err_count)
  );

  function automatic logic [1:0] right_code(input logic [7:0] s);
    return s[7] ? 2'b01 : 2'b11;
  endfunction

  task automatic load_sample(input int a, input logic [7:0] d);
    load_en = 1'b1; load_addr = AW'(a); load_data = d;
    @(posedge clk); #1;
    load_en = 1'b0;
    mem_m[a] = d;
  endtask

  // Start a run, compare the core-facing trace cycle by cycle, then the final status.
  task automatic run_check(input string name, input int inj_load, input int inj_start);
    int mistakes = 0;
    int epochs, total, bad;
    logic [7:0] s, e;
    logic [7:0] first_bad_act, first_bad_exp;
    exp_mask = '0;
    for (int i = 0; i < NS; i++) begin
      s = mem_m[i];
      if (tab[s] !== right_code(s)) begin
        mistakes++;
        exp_mask[i] = 1'b1;
      end
    end
    epochs = (mistakes == 0) ? 1 : MAXE;
    total  = epochs * EPOCH_LEN;
    bad = 0;
    first_bad_act = '0; first_bad_exp = '0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < total; k++) begin
      int pos = k % EPOCH_LEN;
      e = (pos == EPOCH_LEN - 1) ? 8'h00 : mem_m[pos / (ST + 1)];
      if (busy !== 1'b1 || {p_exp_res, p_in} !== e) begin
        if (bad == 0) begin
          first_bad_act = {p_exp_res, p_in};
          first_bad_exp = e;
        end
        bad++;
      end
      load_en = 1'b0; start = 1'b0;
      if (k == inj_load) begin
        load_en = 1'b1; load_addr = '0; load_data = ~mem_m[0];
      end
      if (k == inj_start) start = 1'b1;
      @(posedge clk); #1;
    end
    load_en = 1'b0; start = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s trace: %0d bad cycles, first p_sample=%h expected %h", name, bad,
               first_bad_act, first_bad_exp);
    end
    checks++;
    if ({busy, done, converged} !== {1'b0, 1'b1, (mistakes == 0)}) begin
      errors++;
      $display("FAIL %s status: busy/done/conv=%b%b%b expected 01%b", name, busy, done,
               converged, (mistakes == 0));
    end
    checks++;
    if (epoch_count !== 8'(epochs)) begin
      errors++;
      $display("FAIL %s epoch_count: got %0d expected %0d", name, epoch_count, epochs);
    end
    checks++;
    if (err_count !== 8'(mistakes)) begin
      errors++;
      $display("FAIL %s err_count: got %0d expected %0d", name, err_count, mistakes);
    end
    checks++;
    if (p_in !== 7'd0 || p_exp_res !== 1'b0) begin
      errors++;
      $display("FAIL %s done_pin: got %h expected 00", name, {p_exp_res, p_in});
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
    threshold_in = 8'hA5;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, converged, epoch_count, err_count, p_in, p_exp_res, p_threshold} !== '0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b conv=%b ep=%0d err=%0d p_in=%h exp=%b thr=%h expected all 0",
               busy, done, converged, epoch_count, err_count, p_in, p_exp_res, p_threshold);
    end
    start = 1'b0;
    for (int i = 0; i < NS; i++) mem_m[i] = '0;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_threshold();
    logic [7:0] t;
    for (int i = 0; i < 6; i++) begin
      t = 8'($urandom);
      threshold_in = t;
      @(posedge clk); #1;
      checks++;
      if (p_threshold !== t) begin
        errors++;
        $display("FAIL threshold: got %h expected %h", p_threshold, t);
      end
    end
  endtask

  task automatic test_converge();
    for (int i = 0; i < NS; i++) begin
      logic [7:0] d = {1'b1, 7'($urandom)};
      load_sample(i, d);
      tab[d] = 2'b01;
    end
    run_check("converge", -1, -1);
  endtask

  task automatic test_give_up();
    for (int i = 0; i < NS; i++) begin
      logic [7:0] d = {1'b1, 7'($urandom)};
      load_sample(i, d);
      tab[d] = 2'b11;
    end
    run_check("give_up", -1, -1);
  endtask

  task automatic test_invalid_code();
    for (int i = 0; i < NS; i++) begin
      logic [7:0] d = {1'b0, 7'($urandom)};
      load_sample(i, d);
      tab[d] = 2'b00;
    end
    run_check("invalid_code", -1, -1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      logic all_ok = 1'($urandom_range(0, 1));
      for (int i = 0; i < NS; i++) begin
        logic [7:0] d = 8'($urandom);
        load_sample(i, d);
        tab[d] = all_ok ? right_code(d) : 2'($urandom);
      end
      run_check("random", -1, -1);
    end
  endtask

  task automatic test_protocol();
    logic [7:0] d;
    for (int i = 0; i < NS; i++) begin
      d = {1'b1, 7'($urandom)};
      load_sample(i, d);
      tab[d] = (i == 1) ? 2'b10 : 2'b01;
    end
    run_check("busy_ignore", 5, 8);
    // load+start together while DONE: write lands, start ignored
    d = {1'b1, 7'($urandom)};
    tab[d] = 2'b01;
    load_en = 1'b1; load_addr = AW'(1); load_data = d; start = 1'b1;
    @(posedge clk); #1;
    load_en = 1'b0; start = 1'b0;
    mem_m[1] = d;
    checks++;
    if (busy !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL load_start_done: busy=%b done=%b expected busy=0 done=1", busy, done);
    end
    run_check("after_load_start", -1, -1);
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    tab[8'h00] = 2'b11;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({busy, done, converged, epoch_count, err_count, p_in, p_exp_res} !== '0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b conv=%b ep=%0d err=%0d p_in=%h expected all 0",
               busy, done, converged, epoch_count, err_count, p_in);
    end
    reset = 1'b1;
    for (int i = 0; i < NS; i++) mem_m[i] = '0;
    @(posedge clk); #1;
    // load+start together in IDLE
    d = {1'b1, 7'($urandom)};
    tab[d] = 2'b01;
    load_en = 1'b1; load_addr = AW'(2); load_data = d; start = 1'b1;
    @(posedge clk); #1;
    load_en = 1'b0; start = 1'b0;
    mem_m[2] = d;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL load_start_idle: busy=%b done=%b expected 0 0", busy, done);
    end
    run_check("after_reset_mid", -1, -1);
  endtask

`ifdef MISS_MASK_EN
  task automatic test_miss_mask();
    for (int i = 0; i < NS; i++) begin
      logic [7:0] d = 8'h81 + 8'(i);
      load_sample(i, d);
      tab[d] = (i == 2) ? 2'b11 : 2'b01;
    end
    run_check("miss_mask", -1, -1);
    checks++;
    if (miss_mask !== 4'b0100 || exp_mask !== 4'b0100) begin
      errors++;
      $display("FAIL miss_mask: got %b expected 0100", miss_mask);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) tab[i] = 2'b00;
    test_reset();
    test_threshold();
    test_converge();
    test_give_up();
    test_invalid_code();
    test_random();
    test_protocol();
    test_reset_mid();
`ifdef MISS_MASK_EN
    test_miss_mask();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
